// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared encodings and sizing for the FIFO drain controller.
package fifo_drain_ctrl_pkg;

    localparam int DEF_DATA_BITS = 10;
    localparam int SKID_DEPTH    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

endpackage

// File: rtl/fifo_drain_ctrl_skid.sv
// Two-entry register FIFO that absorbs words already in flight from the FIFO read port.
module skid_buf_2
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic [DATA_BITS-1:0] head_o,
    output logic [1:0]           count_o
);

    logic [DATA_BITS-1:0] ent0_q, ent0_d;
    logic [DATA_BITS-1:0] ent1_q, ent1_d;
    logic [1:0]           count_q, count_d;

    // Entry 0 is always the head; entries shift down on pop.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = data_i;
                else                 ent1_d = data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = data_i;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) count_q <= 2'd0;
        else        count_q <= count_d;
    end

    // Contents are don't-care while count is zero, so they carry no reset.
    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign head_o  = ent0_q;
    assign count_o = count_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// FIFO read-side engine: credit-limited read strobe, skid buffer and registered output stage.
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_in,
    input  logic                 fifo_empty_in,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    output logic                 fifo_read_out,
    input  logic                 pause_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic [CNT_BITS-1:0]  words_out,
    output logic                 idle_out
);

    localparam logic [2:0] CREDIT_LIM = 3'(SKID_DEPTH);

    state_e               state_q, state_d;
    logic                 rd_pending_q;
    logic [1:0]           skid_count;
    logic [DATA_BITS-1:0] skid_head;
    logic                 pop;
    logic                 rd;
    logic [2:0]           credit;
    logic                 valid_q;
    logic [DATA_BITS-1:0] data_q;
    logic [CNT_BITS-1:0]  words_q;

    // Credit counts words held plus the one in flight, net of this cycle's pop.
    always_comb begin
        pop    = (state_q != ST_IDLE) && (skid_count != 2'd0) && !pause_in;
        credit = {1'b0, skid_count} + {2'b00, rd_pending_q} - {2'b00, pop};
        rd     = reset && (state_q == ST_RUN) && !fifo_empty_in && (credit < CREDIT_LIM);
    end

    assign fifo_read_out = rd;

    skid_buf_2 #(
        .DATA_BITS(DATA_BITS)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .push_i (rd_pending_q),
        .pop_i  (pop),
        .data_i (fifo_data_in),
        .head_o (skid_head),
        .count_o(skid_count)
    );

    // FLUSH only retires to IDLE once nothing is buffered or in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable_in) state_d = ST_RUN;
            ST_RUN:   if (!enable_in) state_d = ST_FLUSH;
            ST_FLUSH: begin
                if (enable_in)
                    state_d = ST_RUN;
                else if ((skid_count == 2'd0) && !rd_pending_q)
                    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            words_q <= '0;
        end else begin
            valid_q <= pop;
            if (pop) begin
                data_q  <= skid_head;
                words_q <= words_q + CNT_BITS'(1);
            end
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign words_out = words_q;
    assign idle_out  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed scoreboard bench for fifo_drain_ctrl with a behavioural FIFO on the read side.
module tb_fifo_drain_ctrl;

    localparam int DW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable_in = 1'b0;
    logic          fifo_empty_in = 1'b1;
    logic [DW-1:0] fifo_data_in = '0;
    logic          fifo_read_out;
    logic          pause_in = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [CW-1:0] words_out;
    logic          idle_out;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            rd_cnt = 0;
    int            dv_cnt = 0;
    logic [CW-1:0] exp_cnt = '0;
    bit            chk_ahead = 1'b0;

    fifo_drain_ctrl #(
        .DATA_BITS(DW),
        .CNT_BITS (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_in    (enable_in),
        .fifo_empty_in(fifo_empty_in),
        .fifo_data_in (fifo_data_in),
        .fifo_read_out(fifo_read_out),
        .pause_in     (pause_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .words_out    (words_out),
        .idle_out     (idle_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Behavioural FIFO with one-cycle registered read data.
    always @(posedge clk) begin
        if (fifo_read_out) begin
            vectors++;
            if (fifo_q.size() == 0) begin
                miscompares++;
                $display("FAIL read_while_empty: fifo_read_out=1, expected 0 with FIFO empty");
            end else begin
                fifo_data_in <= fifo_q.pop_front();
                rd_cnt++;
            end
            fifo_empty_in <= (fifo_q.size() == 0);
        end
    end

    // Monitor: every delivered word is checked against the scoreboard queue.
    always @(negedge clk) begin
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: data_out=0x%0h, expected no delivery", data_out);
            end else begin
                check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
                exp_cnt = exp_cnt + 8'd1;
                check("words_out", 32'(words_out), 32'(exp_cnt));
                dv_cnt++;
            end
        end
        if (chk_ahead) begin
            vectors++;
            if (rd_cnt - dv_cnt > 2) begin
                miscompares++;
                $display("FAIL read_ahead: got %0d words ahead, expected at most 2", rd_cnt - dv_cnt);
            end
        end
    end

    task automatic load(input logic [DW-1:0] w, input bit expect_it);
        fifo_q.push_back(w);
        fifo_empty_in = 1'b0;
        if (expect_it) exp_q.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        enable_in = 1'b0;
        pause_in  = 1'b0;
        repeat (2) @(negedge clk);
        fifo_q.delete();
        fifo_empty_in = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        reset   = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rd_log[12];
        logic vl_log[12];
        int   first_rd;
        int   first_vl;
        int   nr;
        int   run;
        int   n;

        // Reset: enable high and FIFO non-empty must still give no read.
        load(10'h0AA, 1'b0);
        enable_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_words", 32'(words_out), 32'd0);
        check("rst_idle", 32'(idle_out), 32'd1);
        check("rst_read", 32'(fifo_read_out), 32'd0);

        // Basic stream 0x001..0x004.
        do_reset();
        for (int i = 1; i <= 4; i++) load(DW'(i), 1'b1);
        enable_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rd_log[i] = fifo_read_out;
            vl_log[i] = valid_out;
        end
        first_rd = -1;
        first_vl = -1;
        nr = 0;
        for (int i = 0; i < 12; i++) begin
            if (rd_log[i]) nr++;
            if (rd_log[i] && first_rd < 0) first_rd = i;
            if (vl_log[i] && first_vl < 0) first_vl = i;
        end
        run = 0;
        for (int i = 0; i < 12; i++)
            if (first_vl >= 0 && i >= first_vl && i < first_vl + 4 && vl_log[i]) run++;
        check("basic_reads", 32'(nr), 32'd4);
        // Read in cycle t, captured end of t+1, valid_out registered end of t+2, seen in t+3.
        check("basic_latency", 32'(first_vl - first_rd), 32'd3);
        check("basic_valid_run", 32'(run), 32'd4);
        check("basic_words", 32'(words_out), 32'd4);
        check("basic_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: pause cycles 3..7.
        do_reset();
        rd_cnt = 0;
        dv_cnt = 0;
        for (int i = 0; i < 6; i++) load(DW'(10'h010 + i), 1'b1);
        enable_in = 1'b1;
        chk_ahead = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pause_in = (i >= 3 && i < 8);
            #1;
            if (i >= 4 && i < 8) check("pause_no_read", 32'(fifo_read_out), 32'd0);
        end
        drain(40);
        chk_ahead = 1'b0;
        check("bp_words", 32'(words_out), 32'd6);

        // Empty guard.
        do_reset();
        enable_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("empty_read", 32'(fifo_read_out), 32'd0);
            check("empty_valid", 32'(valid_out), 32'd0);
            check("empty_idle", 32'(idle_out), 32'd0);
        end

        // Flush after the second read.
        do_reset();
        load(10'h3FF, 1'b1);
        load(10'h155, 1'b1);
        load(10'h2AA, 1'b0);
        enable_in = 1'b1;
        nr = 0;
        for (int i = 0; i < 10 && nr < 2; i++) begin
            @(negedge clk);
            #1;
            if (fifo_read_out) nr++;
        end
        enable_in = 1'b0;
        check("flush_reads", 32'(nr), 32'd2);
        n = 0;
        while (!idle_out && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("flush_idle", 32'(idle_out), 32'd1);
        check("flush_delivered", 32'(exp_q.size()), 32'd0);
        check("flush_fifo_left", 32'(fifo_q.size()), 32'd1);
        check("flush_fifo_word", 32'(fifo_q[0]), 32'h2AA);
        check("flush_words", 32'(words_out), 32'd2);

        // Counter wrap after 257 words.
        do_reset();
        for (int i = 0; i < 257; i++) load(DW'(i), 1'b1);
        enable_in = 1'b1;
        drain(400);
        check("wrap_words", 32'(words_out), 32'd1);

        // Reset with the skid buffer full.
        do_reset();
        for (int i = 0; i < 6; i++) load(DW'(10'h100 + i), 1'b0);
        pause_in  = 1'b1;
        enable_in = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_paused_valid", 32'(valid_out), 32'd0);
        check("mid_fifo_left", 32'(fifo_q.size()), 32'd4);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_words", 32'(words_out), 32'd0);
        check("mid_rst_idle", 32'(idle_out), 32'd1);
        check("mid_rst_read", 32'(fifo_read_out), 32'd0);
        // Skid contents are gone: only the words still in the FIFO may appear.
        for (int i = 0; i < fifo_q.size(); i++) exp_q.push_back(fifo_q[i]);
        exp_cnt  = '0;
        reset    = 1'b1;
        pause_in = 1'b0;
        drain(40);
        check("mid_after_words", 32'(words_out), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
